// File: rtl/serial_regfile_engine_if.sv
// Handshake and data bundle between a core's sequencer-side logic and serial_regfile_engine.
// The master drives requests; the slave returns the digit stream, the done pulse and the assembled words.
interface serial_regfile_engine_if #(
  parameter int XLEN  = 32,
  parameter int DIGIT = 2,
  parameter int SELW  = 4
);
  logic              start;
  logic [1:0]        op;
  logic [SELW-1:0]   rs1_sel;
  logic [SELW-1:0]   rs2_sel;
  logic [SELW-1:0]   rd_sel;
  logic [XLEN-1:0]   wr_data;
  logic              busy;
  logic              digit_valid;
  logic [DIGIT-1:0]  rs1_digit;
  logic [DIGIT-1:0]  rs2_digit;
  logic              done;
  logic [XLEN-1:0]   rs1_word;
  logic [XLEN-1:0]   rs2_word;

  modport master (
    output start, op, rs1_sel, rs2_sel, rd_sel, wr_data,
    input  busy, digit_valid, rs1_digit, rs2_digit, done, rs1_word, rs2_word
  );

  modport slave (
    input  start, op, rs1_sel, rs2_sel, rd_sel, wr_data,
    output busy, digit_valid, rs1_digit, rs2_digit, done, rs1_word, rs2_word
  );
endinterface

// File: rtl/serial_regfile_engine.sv
// Digit-serial register file: one start streams rs1/rs2 out LSB-first over XLEN/DIGIT cycles,
// optionally rewriting rd in the same pass; assembled words are presented with the done pulse.
module serial_regfile_engine #(
  parameter int XLEN     = 32,
  parameter int DIGIT    = 2,
  parameter int NUM_REGS = 16,
  parameter int SELW     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_regfile_engine_if.slave bus
);

  localparam int N    = XLEN / DIGIT;
  localparam int CNTW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t            state_q, state_d;
  logic [CNTW-1:0]   cnt_q;
  logic [1:0]        op_q;
  logic [SELW-1:0]   rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0]   wdat_q;
  logic [XLEN-1:0]   regs [NUM_REGS];
  logic [XLEN-1:0]   rs1_word_q, rs2_word_q;
  logic              accept;
  logic              in_xfer;
  logic              wr_en;
  logic [DIGIT-1:0]  d1, d2;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // DONE accepts start exactly like IDLE so passes can run back to back.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (cnt_q == CNTW'(N - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_xfer = (state_q == XFER);
  assign wr_en   = op_q[1] && (rd_q != '0) && (int'(rd_q) < NUM_REGS);

  // Register 0 and out-of-range selects read as zero.
  always_comb begin
    d1 = '0;
    d2 = '0;
    if (rs1_q != '0 && int'(rs1_q) < NUM_REGS) d1 = regs[rs1_q][DIGIT-1:0];
    if (rs2_q != '0 && int'(rs2_q) < NUM_REGS) d2 = regs[rs2_q][DIGIT-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      op_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      rd_q   <= '0;
      wdat_q <= '0;
    end else if (accept) begin
      cnt_q  <= '0;
      op_q   <= bus.op;
      rs1_q  <= bus.rs1_sel;
      rs2_q  <= bus.rs2_sel;
      rd_q   <= bus.rd_sel;
      wdat_q <= bus.wr_data;
    end else if (in_xfer) begin
      cnt_q  <= cnt_q + 1'b1;
      wdat_q <= {{DIGIT{1'b0}}, wdat_q[XLEN-1:DIGIT]};
    end
  end

  // Every register rotates each transfer cycle; rd takes the incoming write digit instead of its own LSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (in_xfer) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (wr_en && rd_q == SELW'(i))
          regs[i] <= {wdat_q[DIGIT-1:0], regs[i][XLEN-1:DIGIT]};
        else
          regs[i] <= {regs[i][DIGIT-1:0], regs[i][XLEN-1:DIGIT]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rs1_word_q <= '0;
      rs2_word_q <= '0;
    end else if (in_xfer) begin
      rs1_word_q <= {d1, rs1_word_q[XLEN-1:DIGIT]};
      rs2_word_q <= {d2, rs2_word_q[XLEN-1:DIGIT]};
    end
  end

  assign bus.busy        = in_xfer;
  assign bus.digit_valid = in_xfer;
  assign bus.rs1_digit   = in_xfer ? d1 : '0;
  assign bus.rs2_digit   = in_xfer ? d2 : '0;
  assign bus.done        = (state_q == DONE);
  assign bus.rs1_word    = rs1_word_q;
  assign bus.rs2_word    = rs2_word_q;

endmodule

// File: tb/tb_serial_regfile_engine.sv
// Scoreboard bench for serial_regfile_engine: default build plus DIGIT=1 and DIGIT=8 builds with 32 regs.
module tb_serial_regfile_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  serial_regfile_engine_if #(.XLEN(32), .DIGIT(2), .SELW(4)) bus ();
  serial_regfile_engine_if #(.XLEN(32), .DIGIT(1), .SELW(5)) b1 ();
  serial_regfile_engine_if #(.XLEN(32), .DIGIT(8), .SELW(5)) b8 ();

  serial_regfile_engine #(.XLEN(32), .DIGIT(2), .NUM_REGS(16), .SELW(4)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus));
  serial_regfile_engine #(.XLEN(32), .DIGIT(1), .NUM_REGS(32), .SELW(5)) dut_d1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  serial_regfile_engine #(.XLEN(32), .DIGIT(8), .NUM_REGS(32), .SELW(5)) dut_d8 (
    .clk(clk), .rst_n(rst_n), .bus(b8));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] w1;
    logic [31:0] w2;
    int          t;
  } exp_t;

  exp_t        q[$];
  logic [31:0] model [16];

  function automatic logic [31:0] mrd(input logic [3:0] s);
    return (s == 4'd0) ? 32'd0 : model[s];
  endfunction

  // Monitor for the default build: rebuilds words from the digit stream and checks them at done.
  int          dcnt;
  logic [31:0] acc1, acc2;
  logic        prev_done;
  exp_t        e;
  always @(negedge clk) begin
    if (!rst_n) begin
      dcnt      = 0;
      prev_done = 1'b0;
    end else begin
      if (bus.digit_valid) begin
        dcnt++;
        acc1 = {bus.rs1_digit, acc1[31:2]};
        acc2 = {bus.rs2_digit, acc2[31:2]};
      end
      if (prev_done) check("done_one_cycle", bus.done, 1'b0);
      if (bus.done && !prev_done) begin
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("rs1_word", bus.rs1_word, e.w1);
          check("rs2_word", bus.rs2_word, e.w2);
          check("rs1_digits", acc1, e.w1);
          check("rs2_digits", acc2, e.w2);
          check("digit_count", dcnt, 16);
          check("done_latency", cyc, e.t + 17);
        end
        dcnt = 0;
      end
      prev_done = bus.done;
    end
  end

  // Monitors for the alternate builds: digit count of each pass and number of passes finished.
  int c1, c8, last1, last8, nd1, nd8;
  always @(negedge clk) begin
    if (!rst_n) begin
      c1 = 0; c8 = 0; nd1 = 0; nd8 = 0; last1 = 0; last8 = 0;
    end else begin
      if (b1.digit_valid) c1++;
      if (b8.digit_valid) c8++;
      if (b1.done) begin last1 = c1; c1 = 0; nd1++; end
      if (b8.done) begin last8 = c8; c8 = 0; nd8++; end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("pass_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic [1:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                       input logic [3:0] rd, input logic [31:0] data);
    exp_t x;
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs1_sel = rs1;
    bus.rs2_sel = rs2;
    bus.rd_sel  = rd;
    bus.wr_data = data;
    x.w1 = mrd(rs1);
    x.w2 = mrd(rs2);
    x.t  = cyc;
    q.push_back(x);
    if (op[1] && rd != 4'd0) model[rd] = data;
  endtask

  task automatic pass(input logic [1:0] op, input logic [3:0] rs1, input logic [3:0] rs2,
                      input logic [3:0] rd, input logic [31:0] data);
    @(negedge clk);
    drive(op, rs1, rs2, rd, data);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
  endtask

  task automatic alt_pass(input logic [1:0] op, input logic [4:0] rs1, input logic [4:0] rd,
                          input logic [31:0] data, input int n);
    @(negedge clk);
    b1.start = 1'b1; b1.op = op; b1.rs1_sel = rs1; b1.rs2_sel = 5'd0; b1.rd_sel = rd; b1.wr_data = data;
    b8.start = 1'b1; b8.op = op; b8.rs1_sel = rs1; b8.rs2_sel = 5'd0; b8.rd_sel = rd; b8.wr_data = data;
    @(negedge clk);
    b1.start = 1'b0;
    b8.start = 1'b0;
    for (int i = 0; i < 80 && !(nd1 >= n && nd8 >= n); i++) @(negedge clk);
    check("alt_pass_finished", (nd1 >= n && nd8 >= n), 1'b1);
  endtask

  int s;

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op = 2'b00; bus.rs1_sel = '0; bus.rs2_sel = '0; bus.rd_sel = '0; bus.wr_data = '0;
    b1.start  = 1'b0; b1.op  = 2'b00; b1.rs1_sel  = '0; b1.rs2_sel  = '0; b1.rd_sel  = '0; b1.wr_data  = '0;
    b8.start  = 1'b0; b8.op  = 2'b00; b8.rs1_sel  = '0; b8.rs2_sel  = '0; b8.rd_sel  = '0; b8.wr_data  = '0;
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_digit_valid", bus.digit_valid, 1'b0);
    check("rst_digits", {bus.rs1_digit, bus.rs2_digit}, 4'd0);
    check("rst_words", {bus.rs1_word, bus.rs2_word}, 64'd0);
    rst_n = 1'b1;

    pass(2'b01, 4'd3, 4'd5, 4'd0, 32'd0);
    pass(2'b10, 4'd3, 4'd5, 4'd3, 32'hDEADBEEF);
    pass(2'b01, 4'd3, 4'd0, 4'd0, 32'd0);
    pass(2'b10, 4'd0, 4'd3, 4'd0, 32'hFFFFFFFF);
    pass(2'b01, 4'd0, 4'd3, 4'd0, 32'd0);
    pass(2'b10, 4'd1, 4'd2, 4'd7, 32'h12345678);
    pass(2'b11, 4'd7, 4'd3, 4'd7, 32'hCAFEBABE);
    pass(2'b01, 4'd7, 4'd3, 4'd0, 32'd0);
    pass(2'b00, 4'd5, 4'd7, 4'd5, 32'h11111111);
    pass(2'b01, 4'd5, 4'd15, 4'd0, 32'd0);
    pass(2'b11, 4'd15, 4'd15, 4'd15, 32'h0F0F00F0);
    pass(2'b01, 4'd15, 4'd7, 4'd0, 32'd0);

    // start held high: three passes 17 cycles apart
    @(negedge clk);
    s = cyc;
    drive(2'b01, 4'd3, 4'd7, 4'd0, 32'd0);
    drive(2'b01, 4'd3, 4'd7, 4'd0, 32'd0);
    drive(2'b01, 4'd3, 4'd7, 4'd0, 32'd0);
    q[1].t = s + 17;
    q[2].t = s + 34;
    repeat (35) @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // start pulse during busy must be ignored
    @(negedge clk);
    drive(2'b01, 4'd7, 4'd3, 4'd0, 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy_mid_pass", bus.busy, 1'b1);
    bus.start = 1'b1; bus.op = 2'b11; bus.rd_sel = 4'd7; bus.wr_data = 32'h0;
    @(negedge clk);
    bus.start = 1'b0; bus.op = 2'b01;
    wait_idle();
    repeat (20) @(negedge clk);
    pass(2'b01, 4'd7, 4'd0, 4'd0, 32'd0);

    // reset at transfer cycle 8 of a write to reg 4
    @(negedge clk);
    s = cyc;
    drive(2'b10, 4'd1, 4'd2, 4'd4, 32'hA5A5A5A5);
    @(negedge clk);
    bus.start = 1'b0;
    while (cyc < s + 9) @(negedge clk);
    check("busy_before_reset", bus.busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    for (int i = 0; i < 16; i++) model[i] = 32'd0;
    check("post_rst_busy", bus.busy, 1'b0);
    check("post_rst_words", {bus.rs1_word, bus.rs2_word}, 64'd0);
    pass(2'b01, 4'd4, 4'd3, 4'd0, 32'd0);

    // DIGIT=1 and DIGIT=8 builds with 32 registers
    alt_pass(2'b10, 5'd31, 5'd31, 32'h80000001, 1);
    alt_pass(2'b01, 5'd31, 5'd0, 32'd0, 2);
    check("d1_rs1_word", b1.rs1_word, 32'h80000001);
    check("d8_rs1_word", b8.rs1_word, 32'h80000001);
    check("d1_rs2_word", b1.rs2_word, 32'd0);
    check("d8_rs2_word", b8.rs2_word, 32'd0);
    check("d1_digit_count", last1, 32);
    check("d8_digit_count", last8, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
